// File: rtl/sd_pkg.sv
// Shared SD host definitions: frame geometry, CRC7 generator and the response FSM states.
package sd_pkg;

  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int RESP_LEN = 48;
  localparam int DIR_BIT  = 46;
  localparam int IDX_MSB  = 45;
  localparam int ARG_MSB  = 39;
  localparam int CRC_MSB  = 7;
  localparam int CRC_BITS = 40;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_RECV,
    ST_DONE
  } state_t;

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1) register, shared by the CMD transmitter and receiver.
// Latency: updated crc visible the clk after en. No backpressure; clr has priority over en.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  logic fb;
  assign fb = crc[6] ^ din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 7'h00;
    end else if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    end
  end

endmodule

// File: rtl/sd_resp_rx.sv
// SD CMD-line response receiver: waits for the start bit, shifts in 48 bits, checks CRC7/dir/end.
// Latency: done 1 clk after the end-bit strobe. No backpressure; bit_stb paces all progress.
module sd_resp_rx
  import sd_pkg::*;
#(
  parameter int NCR_MAX = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bit_stb,
  input  logic        cmd_in,
  input  logic        arm,
  input  logic        no_crc,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic        crc_ok,
  output logic        dir_err,
  output logic        end_err,
  output logic [5:0]  resp_index,
  output logic [31:0] resp_arg
);

  localparam int NCW = $clog2(NCR_MAX + 1);

  state_t                state;
  logic [NCW-1:0]        ncr_cnt;
  logic [5:0]            bit_cnt;
  logic [RESP_LEN-3:0]   sr;
  logic [RESP_LEN-2:0]   frm;
  logic                  no_crc_q;
  logic                  crc_clr;
  logic                  crc_en;
  logic [6:0]            crc_val;

  // sr holds frame bits 46..1 by the time the end bit arrives; frm lines up with frame positions.
  assign frm     = {sr, cmd_in};
  assign crc_clr = (state == ST_IDLE);
  assign crc_en  = bit_stb &&
                   (((state == ST_WAIT_START) && !cmd_in) ||
                    ((state == ST_RECV) && (bit_cnt < 6'(CRC_BITS))));

  sd_crc7 u_crc7 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .din   (cmd_in),
    .crc   (crc_val)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ncr_cnt    <= '0;
      bit_cnt    <= '0;
      sr         <= '0;
      no_crc_q   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
      crc_ok     <= 1'b0;
      dir_err    <= 1'b0;
      end_err    <= 1'b0;
      resp_index <= '0;
      resp_arg   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          ncr_cnt <= '0;
          bit_cnt <= '0;
          if (arm) begin
            no_crc_q   <= no_crc;
            busy       <= 1'b1;
            timeout    <= 1'b0;
            crc_ok     <= 1'b0;
            dir_err    <= 1'b0;
            end_err    <= 1'b0;
            resp_index <= '0;
            resp_arg   <= '0;
            state      <= ST_WAIT_START;
          end
        end
        ST_WAIT_START: begin
          if (bit_stb) begin
            if (!cmd_in) begin
              bit_cnt <= 6'd1;
              state   <= ST_RECV;
            end else begin
              ncr_cnt <= ncr_cnt + 1'b1;
              if (ncr_cnt == NCW'(NCR_MAX - 1)) begin
                timeout <= 1'b1;
                done    <= 1'b1;
                busy    <= 1'b0;
                state   <= ST_DONE;
              end
            end
          end
        end
        ST_RECV: begin
          if (bit_stb) begin
            sr      <= {sr[RESP_LEN-4:0], cmd_in};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 6'(RESP_LEN - 1)) begin
              resp_index <= frm[IDX_MSB -: 6];
              resp_arg   <= frm[ARG_MSB -: 32];
              crc_ok     <= no_crc_q || (frm[CRC_MSB -: 7] == crc_val);
              dir_err    <= frm[DIR_BIT];
              end_err    <= !frm[0];
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_resp_rx.sv
// Directed bench for sd_resp_rx: expected responses queued at arm time, compared at done.
module tb_sd_resp_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_stb = 1'b0;
  logic        cmd_in = 1'b1;
  logic        arm = 1'b0;
  logic        no_crc = 1'b0;
  logic        busy, done, timeout, crc_ok, dir_err, end_err;
  logic [5:0]  resp_index;
  logic [31:0] resp_arg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] arg;
    logic        crc;
    logic        dir;
    logic        endb;
    logic        to;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sd_resp_rx #(.NCR_MAX(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_stb    (bit_stb),
    .cmd_in     (cmd_in),
    .arm        (arm),
    .no_crc     (no_crc),
    .busy       (busy),
    .done       (done),
    .timeout    (timeout),
    .crc_ok     (crc_ok),
    .dir_err    (dir_err),
    .end_err    (end_err),
    .resp_index (resp_index),
    .resp_arg   (resp_arg)
  );

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_resp(input logic [5:0] idx, input logic [31:0] arg,
                             input logic c, input logic d, input logic e, input logic t);
    exp_t x;
    x.idx = idx; x.arg = arg; x.crc = c; x.dir = d; x.endb = e; x.to = t;
    sb.push_back(x);
  endtask

  task automatic drive_bit(input logic b, input int gap);
    bit_stb = 1'b1;
    cmd_in  = b;
    @(posedge clk); #1;
    bit_stb = 1'b0;
    cmd_in  = 1'b1;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // coinc drives a start-bit-looking strobe in the arm cycle; it must not be counted.
  task automatic do_arm(input logic nc, input logic coinc);
    arm     = 1'b1;
    no_crc  = nc;
    bit_stb = coinc;
    cmd_in  = !coinc;
    @(posedge clk); #1;
    arm     = 1'b0;
    no_crc  = 1'b0;
    bit_stb = 1'b0;
    cmd_in  = 1'b1;
    chk("busy_after_arm", busy, 1);
  endtask

  task automatic send_frame(input logic [47:0] frame, input int idle, input int gap, input logic mid_arm);
    repeat (idle) drive_bit(1'b1, gap);
    for (int i = 47; i >= 0; i--) begin
      drive_bit(frame[i], (i == 0) ? 0 : gap);
      if (mid_arm && i == 30) begin
        arm = 1'b1;
        @(posedge clk); #1;
        arm = 1'b0;
      end
    end
  endtask

  task automatic check_result(input string tag);
    exp_t e;
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy"}, busy, 0);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_idx"}, resp_index, e.idx);
      chk({tag, "_arg"}, resp_arg, e.arg);
      chk({tag, "_crc_ok"}, crc_ok, e.crc);
      chk({tag, "_dir_err"}, dir_err, e.dir);
      chk({tag, "_end_err"}, end_err, e.endb);
      chk({tag, "_timeout"}, timeout, e.to);
    end else begin
      chk({tag, "_sb_underflow"}, sb.size(), 1);
    end
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic seen_done;
    logic [47:0] f;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {busy, done, timeout, crc_ok, dir_err, end_err, resp_index, resp_arg}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean R7, with an arm pulse mid-frame that must be ignored.
    expect_resp(6'h08, 32'h0000_01AA, 1, 0, 0, 0);
    do_arm(1'b0, 1'b0);
    send_frame(48'h08_00_00_01_AA_13, 5, 1, 1'b1);
    check_result("r7");
    repeat (3) @(posedge clk);
    #1;
    chk("r7_hold_arg", resp_arg, 32'h0000_01AA);

    expect_resp(6'h08, 32'h0000_01BA, 0, 0, 0, 0);
    do_arm(1'b0, 1'b0);
    send_frame(48'h08_00_00_01_BA_13, 2, 0, 1'b0);
    check_result("r7_bitflip");

    expect_resp(6'h00, 32'h0000_0000, 1, 1, 0, 0);
    do_arm(1'b0, 1'b0);
    send_frame(48'h40_00_00_00_00_95, 0, 2, 1'b0);
    check_result("cmd0_form");

    expect_resp(6'h3F, 32'h80FF_8000, 1, 0, 0, 0);
    do_arm(1'b1, 1'b0);
    send_frame(48'h3F_80_FF_80_00_FF, 1, 0, 1'b0);
    check_result("r3_nocrc");

    // Reset after 20 bits of a valid frame: everything drops, no done appears.
    f = 48'h08_00_00_01_AA_13;
    do_arm(1'b0, 1'b0);
    for (int i = 47; i >= 28; i--) drive_bit(f[i], 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {busy, done, timeout, crc_ok, dir_err, end_err, resp_index, resp_arg}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 27; i >= 0; i--) begin
      drive_bit(f[i], 0);
      seen_done = seen_done | done;
    end
    repeat (3) begin
      @(posedge clk); #1;
      seen_done = seen_done | done;
    end
    chk("midrst_no_done", seen_done, 0);
    chk("midrst_busy", busy, 0);

    expect_resp(6'h08, 32'h0000_01AA, 1, 0, 0, 0);
    do_arm(1'b0, 1'b1);
    send_frame(48'h08_00_00_01_AA_13, 3, 1, 1'b0);
    check_result("rearm_r7");

    expect_resp(6'h08, 32'h0000_01AA, 1, 0, 1, 0);
    do_arm(1'b0, 1'b0);
    send_frame(48'h08_00_00_01_AA_12, 0, 1, 1'b0);
    check_result("end_bit0");

    expect_resp(6'h00, 32'h0000_0000, 0, 0, 0, 1);
    do_arm(1'b0, 1'b0);
    repeat (63) drive_bit(1'b1, 0);
    chk("timeout_early", done, 0);
    drive_bit(1'b1, 0);
    check_result("timeout");

    chk("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
